// File: rtl/register_file_mp_if.sv
// Port bundle for register_file_mp: packed read/write ports, reservation strobe
// and the busy scoreboard. The decode/writeback side uses master, the file uses slave.
interface register_file_mp_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_L   = 32,
  parameter int ADDR_W   = (ADDR_L > 1) ? $clog2(ADDR_L) : 1,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2
);
  logic [RD_PORTS*ADDR_W-1:0] rd_addr;
  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic [RD_PORTS-1:0]        rd_ready;
  logic [WR_PORTS*ADDR_W-1:0] wr_addr;
  logic [WR_PORTS*DATA_W-1:0] wr_data;
  logic [WR_PORTS-1:0]        wr_en;
  logic [ADDR_W-1:0]          rsv_addr;
  logic                       rsv_en;
  logic [ADDR_L-1:0]          busy;

  modport master (
    output rd_addr, wr_addr, wr_data, wr_en, rsv_addr, rsv_en,
    input  rd_data, rd_ready, busy
  );
  modport slave (
    input  rd_addr, wr_addr, wr_data, wr_en, rsv_addr, rsv_en,
    output rd_data, rd_ready, busy
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-ported register file with optional hardwired zero register, same-cycle
// write-to-read bypass and a per-register busy scoreboard for RAW stalls.
module register_file_mp #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_L   = 32,
  parameter int                ADDR_W   = (ADDR_L > 1) ? $clog2(ADDR_L) : 1,
  parameter int                RD_PORTS = 2,
  parameter int                WR_PORTS = 2,
  parameter logic [DATA_W-1:0] RESET    = '0,
  parameter bit                ZERO_REG = 1'b1,
  parameter bit                BYPASS   = 1'b1
) (
  input logic               clock,
  input logic               reset_n,
  register_file_mp_if.slave bus
);

  logic [DATA_W-1:0] regs_q [ADDR_L];
  logic [DATA_W-1:0] regs_d [ADDR_L];
  logic [ADDR_L-1:0] busy_q;
  logic [ADDR_L-1:0] busy_d;

  // True when the address names a real register that may be written or reserved.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return (int'(a) < ADDR_L) && !(ZERO_REG && (a == '0));
  endfunction

  // Ports are scanned in ascending order so the highest enabled port wins a collision;
  // the reservation is applied last so a newly issued producer keeps the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (bus.wr_en[p] && addr_live(bus.wr_addr[p*ADDR_W +: ADDR_W])) begin
        regs_d[bus.wr_addr[p*ADDR_W +: ADDR_W]] = bus.wr_data[p*DATA_W +: DATA_W];
        busy_d[bus.wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (bus.rsv_en && addr_live(bus.rsv_addr)) begin
      busy_d[bus.rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ADDR_L; i++) begin
        regs_q[i] <= RESET;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign bus.busy = busy_q;

  logic [RD_PORTS*DATA_W-1:0] rd_data_c;
  logic [RD_PORTS-1:0]        rd_ready_c;

  for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] data_c;
    logic              ready_c;

    assign ra = bus.rd_addr[r*ADDR_W +: ADDR_W];

    // Writes presented while reset is held are dropped, so they must not bypass either.
    always_comb begin
      data_c  = '0;
      ready_c = 1'b1;
      if ((int'(ra) < ADDR_L) && !(ZERO_REG && (ra == '0))) begin
        data_c  = regs_q[ra];
        ready_c = ~busy_q[ra];
        if (BYPASS && reset_n) begin
          for (int p = 0; p < WR_PORTS; p++) begin
            if (bus.wr_en[p] && (bus.wr_addr[p*ADDR_W +: ADDR_W] == ra)) begin
              data_c  = bus.wr_data[p*DATA_W +: DATA_W];
              ready_c = 1'b1;
            end
          end
        end
      end
    end

    assign rd_data_c[r*DATA_W +: DATA_W] = data_c;
    assign rd_ready_c[r]                 = ready_c;
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_ready = rd_ready_c;

endmodule
